// File: rtl/list_sum_datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : list_sum_datapath_pkg
//  Purpose  : Shared defaults and select-line encodings for the linked-list
//             summing datapath and its sequencing FSM.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package list_sum_datapath_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_MAX_STEPS = 15;

  // Select-line encodings shared with the FSM
  localparam logic SUM_CLR   = 1'b0;
  localparam logic SUM_ACC   = 1'b1;
  localparam logic NEXT_HEAD = 1'b0;
  localparam logic NEXT_MEM  = 1'b1;
  localparam logic A_VAL     = 1'b0;
  localparam logic A_LINK    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/list_sum_datapath_list_mem.sv
`default_nettype none
// ============================================================================
//  Module   : list_mem
//  Purpose  : Node memory, 2**ADDR_W x DATA_W. One synchronous write port and
//             one asynchronous read port. A write and a read to the same
//             address in one cycle returns the old word; the new word is
//             visible from the following cycle.
//  Ports    : clk      - rising-edge clock
//             wr_en    - write strobe
//             wr_addr  - write address
//             wr_data  - write data
//             rd_addr  - read address
//             rd_data  - combinational read data
//  Revision : 1.0  initial release
// ============================================================================
module list_mem
  import list_sum_datapath_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are intentionally not reset: the list survives a datapath reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Array updates only at the edge, so a same-cycle read sees the old word.
  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/list_sum_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : list_sum_datapath
//  Purpose  : Datapath of the linked-list summing engine. Walks nodes laid
//             out as {value @ ptr, link @ ptr+1}, accumulating values into
//             SUM while NEXT follows the links; pointer 0 terminates.
//  Ports    : clk, rst (sync, active-low)
//             head_addr                 - list head pointer
//             wr_en/wr_addr/wr_data     - memory preload port
//             LD_SUM/LD_NEXT/SUM_SEL/NEXT_SEL/A_SEL/DONE - FSM strobes
//             next_zero                 - NEXT==0, loop-exit condition
//             result/result_valid       - SUM captured on DONE rising edge
//             ovf/ptr_err/loop_err      - sticky status flags
//  Revision : 1.0  initial release
// ============================================================================
module list_sum_datapath
  import list_sum_datapath_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_STEPS = DEF_MAX_STEPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] head_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              LD_SUM,
  input  logic              LD_NEXT,
  input  logic              SUM_SEL,
  input  logic              NEXT_SEL,
  input  logic              A_SEL,
  input  logic              DONE,
  output logic              next_zero,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              ovf,
  output logic              ptr_err,
  output logic              loop_err
);

  localparam int                STEP_W     = $clog2(MAX_STEPS + 1);
  localparam logic [STEP_W-1:0] C_STEP_MAX = STEP_W'(MAX_STEPS);

  logic [DATA_W-1:0] sum_q, sum_d;
  logic [ADDR_W-1:0] next_q, next_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              ovf_q, ovf_d;
  logic              ptr_err_q, ptr_err_d;
  logic              loop_err_q, loop_err_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W:0]   w_sum_ext;
  logic              w_mem_we;

  // ADDR_W-bit add wraps naturally: NEXT=max reads its link from address 0.
  assign w_rd_addr = (A_SEL == A_LINK) ? next_q + ADDR_W'(1) : next_q;

  // Reset overrides every input, including the preload port.
  assign w_mem_we  = wr_en & rst;

  list_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_list_mem (
    .clk     (clk),
    .wr_en   (w_mem_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

  // One extra bit to expose the carry-out of the accumulation.
  assign w_sum_ext = {1'b0, sum_q} + {1'b0, w_rd_data};

  always_comb begin
    sum_d          = sum_q;
    next_d         = next_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    ovf_d          = ovf_q;
    ptr_err_d      = ptr_err_q;
    loop_err_d     = loop_err_q;
    step_d         = step_q;
    done_d         = DONE;

    if (LD_SUM) begin
      if (SUM_SEL == SUM_ACC) begin
        sum_d = w_sum_ext[DATA_W-1:0];
        ovf_d = ovf_q | w_sum_ext[DATA_W];
      end else begin
        // Start of a new run: the previous result is stale but kept visible.
        sum_d          = '0;
        ovf_d          = 1'b0;
        result_valid_d = 1'b0;
      end
    end

    if (LD_NEXT) begin
      if (NEXT_SEL == NEXT_MEM) begin
        // Out-of-range link bits are flagged, the truncated pointer still loads.
        next_d    = w_rd_data[ADDR_W-1:0];
        ptr_err_d = ptr_err_q | (|w_rd_data[DATA_W-1:ADDR_W]);
        if (step_q != C_STEP_MAX) begin
          step_d = step_q + STEP_W'(1);
        end
        loop_err_d = loop_err_q | (step_d == C_STEP_MAX);
      end else begin
        next_d     = head_addr;
        ptr_err_d  = 1'b0;
        step_d     = '0;
        loop_err_d = 1'b0;
      end
    end

    // Capture only on the rising edge so a held DONE does not recapture.
    if (DONE && !done_q) begin
      result_d       = sum_q;
      result_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q          <= '0;
      next_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      ovf_q          <= 1'b0;
      ptr_err_q      <= 1'b0;
      loop_err_q     <= 1'b0;
      step_q         <= '0;
      done_q         <= 1'b0;
    end else begin
      sum_q          <= sum_d;
      next_q         <= next_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      ovf_q          <= ovf_d;
      ptr_err_q      <= ptr_err_d;
      loop_err_q     <= loop_err_d;
      step_q         <= step_d;
      done_q         <= done_d;
    end
  end

  assign next_zero    = (next_q == '0);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign ovf          = ovf_q;
  assign ptr_err      = ptr_err_q;
  assign loop_err     = loop_err_q;

endmodule
`default_nettype wire

// File: tb/tb_list_sum_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_list_sum_datapath
//  Purpose  : Self-checking bench for list_sum_datapath. Stimulus pushes
//             expected output values tagged with a cycle number into a
//             queue; a monitor on the falling edge pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_list_sum_datapath;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  localparam int S_NZ   = 0;
  localparam int S_RES  = 1;
  localparam int S_RV   = 2;
  localparam int S_OVF  = 3;
  localparam int S_PERR = 4;
  localparam int S_LERR = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] head_addr = '0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              LD_SUM = 1'b0;
  logic              LD_NEXT = 1'b0;
  logic              SUM_SEL = 1'b0;
  logic              NEXT_SEL = 1'b0;
  logic              A_SEL = 1'b0;
  logic              DONE = 1'b0;
  logic              next_zero;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              ovf;
  logic              ptr_err;
  logic              loop_err;

  list_sum_datapath #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MAX_STEPS (15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .head_addr    (head_addr),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .LD_SUM       (LD_SUM),
    .LD_NEXT      (LD_NEXT),
    .SUM_SEL      (SUM_SEL),
    .NEXT_SEL     (NEXT_SEL),
    .A_SEL        (A_SEL),
    .DONE         (DONE),
    .next_zero    (next_zero),
    .result       (result),
    .result_valid (result_valid),
    .ovf          (ovf),
    .ptr_err      (ptr_err),
    .loop_err     (loop_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: checks every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t        e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.sel)
        S_NZ:    act = {31'd0, next_zero};
        S_RES:   act = result;
        S_RV:    act = {31'd0, result_valid};
        S_OVF:   act = {31'd0, ovf};
        S_PERR:  act = {31'd0, ptr_err};
        default: act = {31'd0, loop_err};
      endcase
      n_tests++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", e.name, act, e.val, cyc);
      end
    end
  end

  task automatic chk(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.sel  = sel;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic ls, input logic ss, input logic ln,
                     input logic ns, input logic as);
    LD_SUM = ls; SUM_SEL = ss; LD_NEXT = ln; NEXT_SEL = ns; A_SEL = as;
    tick();
    LD_SUM = 1'b0; SUM_SEL = 1'b0; LD_NEXT = 1'b0; NEXT_SEL = 1'b0; A_SEL = 1'b0;
  endtask

  task automatic mem_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [ADDR_W-1:0] h);
    head_addr = h;
    ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic val_step();
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic link_step();
    ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic pulse_done(input string name, input logic [31:0] exp_res);
    DONE = 1'b1;
    tick();
    chk({name, "_res"}, S_RES, exp_res);
    chk({name, "_rv"},  S_RV,  32'd1);
    DONE = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_nz", S_NZ, 32'd1);
    chk("rst_res", S_RES, 32'd0);
    chk("rst_rv", S_RV, 32'd0);
    chk("rst_ovf", S_OVF, 32'd0);
    chk("rst_perr", S_PERR, 32'd0);
    chk("rst_lerr", S_LERR, 32'd0);
    rst = 1'b1;

    // 1: three-node list 5 -> 7 -> 9
    mem_wr(4'd2, 32'd5);  mem_wr(4'd3, 32'd6);
    mem_wr(4'd6, 32'd7);  mem_wr(4'd7, 32'd10);
    mem_wr(4'd10, 32'd9); mem_wr(4'd11, 32'd0);
    start_run(4'd2);
    chk("t1_head_nz", S_NZ, 32'd0);
    val_step();
    pulse_done("t1_sum5", 32'd5);
    link_step(); chk("t1_link1_nz", S_NZ, 32'd0);
    val_step();
    pulse_done("t1_sum12", 32'd12);
    link_step(); chk("t1_link2_nz", S_NZ, 32'd0);
    val_step();
    link_step(); chk("t1_link3_nz", S_NZ, 32'd1);
    chk("t1_ovf", S_OVF, 32'd0);
    pulse_done("t1_sum21", 32'd21);

    // 2: overflow 0xFFFFFFFF + 2
    mem_wr(4'd2, 32'hFFFF_FFFF); mem_wr(4'd3, 32'd6);
    mem_wr(4'd6, 32'd2);         mem_wr(4'd7, 32'd0);
    start_run(4'd2);
    chk("t2_start_rv", S_RV, 32'd0);
    chk("t2_start_res_kept", S_RES, 32'd21);
    val_step();
    chk("t2_no_ovf_yet", S_OVF, 32'd0);
    link_step();
    val_step();
    chk("t2_ovf", S_OVF, 32'd1);
    link_step(); chk("t2_end_nz", S_NZ, 32'd1);
    pulse_done("t2_sum1", 32'd1);
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_clr_ovf", S_OVF, 32'd0);
    chk("t2_clr_rv", S_RV, 32'd0);
    chk("t2_clr_res_kept", S_RES, 32'd1);

    // 3: self-loop at node 2
    mem_wr(4'd3, 32'd2);
    start_run(4'd2);
    for (int i = 1; i <= 16; i++) begin
      link_step();
      if (i == 14) chk("t3_lerr_14", S_LERR, 32'd0);
      if (i == 15) chk("t3_lerr_15", S_LERR, 32'd1);
      if (i == 16) chk("t3_lerr_hold", S_LERR, 32'd1);
    end
    chk("t3_nz", S_NZ, 32'd0);
    chk("t3_perr", S_PERR, 32'd0);
    start_run(4'd2);
    chk("t3_lerr_clr", S_LERR, 32'd0);

    // 4: link with bits above the address range
    mem_wr(4'd5, 32'h0001_0004);
    start_run(4'd4);
    link_step();
    chk("t4_perr", S_PERR, 32'd1);
    chk("t4_nz", S_NZ, 32'd0);
    link_step();
    chk("t4_perr_sticky", S_PERR, 32'd1);
    start_run(4'd2);
    chk("t4_perr_clr", S_PERR, 32'd0);

    // 5: wrap NEXT=15 -> link address 0, read/write collision
    mem_wr(4'd0, 32'd100);
    start_run(4'd15);
    chk("t5_nz", S_NZ, 32'd0);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'd200;
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    wr_en = 1'b0;
    pulse_done("t5_old_data", 32'd100);
    ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse_done("t5_new_data", 32'd300);

    // 6: reset mid-walk, then DONE held high
    mem_wr(4'd2, 32'd5);  mem_wr(4'd3, 32'd6);
    mem_wr(4'd6, 32'd7);  mem_wr(4'd7, 32'd10);
    start_run(4'd2);
    val_step();
    pulse_done("t6_pre_sum5", 32'd5);
    link_step();
    val_step();
    rst = 1'b0;
    tick();
    chk("t6_rst_nz", S_NZ, 32'd1);
    chk("t6_rst_res", S_RES, 32'd0);
    chk("t6_rst_rv", S_RV, 32'd0);
    chk("t6_rst_ovf", S_OVF, 32'd0);
    rst = 1'b1;
    start_run(4'd2);
    val_step(); link_step();
    val_step(); link_step();
    val_step(); link_step();
    chk("t6_walk_nz", S_NZ, 32'd1);
    DONE = 1'b1;
    tick();
    chk("t6_cap_res", S_RES, 32'd21);
    chk("t6_cap_rv", S_RV, 32'd1);
    val_step();
    chk("t6_hold1_res", S_RES, 32'd21);
    tick();
    chk("t6_hold2_res", S_RES, 32'd21);
    DONE = 1'b0;
    tick();
    pulse_done("t6_recap", 32'd221);

    tick(); tick();
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
